// File: rtl/tw_info_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// OmpSsManager: shared tw_info memory geometry and arbiter state encoding. (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package OmpSsManager;

  localparam int TW_MEM_BITS  = 4;
  localparam int TW_MEM_SIZE  = 1 << TW_MEM_BITS;
  localparam int TW_INFO_BITS = 112;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } tw_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/tw_info_arbiter_rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick: first set request searching cyclically from last+1. (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module rr_priority_pick #(
  parameter int NUM_REQ  = 2,
  parameter int IDX_BITS = 1
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDX_BITS-1:0] i_last,
  output logic [IDX_BITS-1:0] o_winner,
  output logic                o_found
);

  logic [IDX_BITS-1:0] w_sel;

  // Walk from the farthest candidate inward so the nearest one after last wins.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_sel    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sel = IDX_BITS'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_sel]) begin
        o_winner = w_sel;
        o_found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tw_info_arbiter.sv
// ---------------------------------------------------------------------------
// tw_info_arbiter: non-preemptive round-robin lock on the tw_info BRAM port. (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tw_info_arbiter
  import OmpSsManager::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = TW_MEM_BITS,
  parameter int DATA_BITS = TW_INFO_BITS
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             i_req,
  output logic [NUM_REQ-1:0]             o_gnt,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   i_req_addr,
  input  logic [NUM_REQ-1:0]             i_req_en,
  input  logic [NUM_REQ-1:0]             i_req_we,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_din,
  output logic [NUM_REQ-1:0]             o_rd_valid,
  output logic [DATA_BITS-1:0]           o_rd_data,
  output logic [ADDR_BITS-1:0]           o_tw_info_addr,
  output logic                           o_tw_info_en,
  output logic                           o_tw_info_we,
  output logic [DATA_BITS-1:0]           o_tw_info_din,
  input  logic [DATA_BITS-1:0]           i_tw_info_dout,
  output logic                           o_tw_info_clk
);

  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tw_arb_state_t       r_state;
  logic [IDX_BITS-1:0] r_owner;
  logic [IDX_BITS-1:0] r_last;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rd_valid;

  logic [IDX_BITS-1:0]  w_pick;
  logic                 w_found;
  logic                 w_own_req;
  logic                 w_own_en;
  logic                 w_own_we;
  logic                 w_active;
  logic                 w_rd_fire;
  logic [ADDR_BITS-1:0] w_own_addr;
  logic [DATA_BITS-1:0] w_own_din;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_pick),
    .o_found  (w_found)
  );

  assign w_own_req  = i_req[r_owner];
  assign w_own_en   = i_req_en[r_owner];
  assign w_own_we   = i_req_we[r_owner];
  assign w_own_addr = i_req_addr[int'(r_owner)*ADDR_BITS +: ADDR_BITS];
  assign w_own_din  = i_req_din[int'(r_owner)*DATA_BITS +: DATA_BITS];

  // An access in the cycle the owner drops req is discarded, not forwarded.
  assign w_active  = (r_state == GRANT) && w_own_req;
  assign w_rd_fire = w_active && w_own_en && !w_own_we;

  assign o_tw_info_addr = w_own_addr;
  assign o_tw_info_din  = w_own_din;
  assign o_tw_info_en   = w_active && w_own_en;
  assign o_tw_info_we   = w_active && w_own_we;
  assign o_tw_info_clk  = clk;

  assign o_rd_data  = i_tw_info_dout;
  assign o_gnt      = r_gnt;
  assign o_rd_valid = r_rd_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rd_valid <= '0;
      r_owner    <= '0;
      r_last     <= IDX_BITS'(NUM_REQ - 1);
    end else begin
      // Strobe lands with the BRAM's one-cycle read data.
      r_rd_valid <= w_rd_fire ? (NUM_REQ'(1) << r_owner) : '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_gnt   <= NUM_REQ'(1) << w_pick;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!w_own_req) begin
            r_gnt   <= '0;
            r_last  <= r_owner;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tw_info_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tw_info_arbiter: directed bench for the tw_info round-robin arbiter. (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tw_info_arbiter;

  localparam int W = 112;
  localparam int A = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [1:0]     req;
  logic [1:0]     gnt;
  logic [2*A-1:0] req_addr;
  logic [1:0]     req_en;
  logic [1:0]     req_we;
  logic [2*W-1:0] req_din;
  logic [1:0]     rd_valid;
  logic [W-1:0]   rd_data;
  logic [A-1:0]   tw_addr;
  logic           tw_en;
  logic           tw_we;
  logic [W-1:0]   tw_din;
  logic [W-1:0]   tw_dout;
  logic           tw_clk;

  logic [W-1:0]   mem [16];
  int             vectors = 0;
  int             miscompares = 0;

  localparam logic [W-1:0] WR_WORD = {1'b1, 95'h0, 16'h1234};

  tw_info_arbiter #(.NUM_REQ(2), .ADDR_BITS(A), .DATA_BITS(W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_req          (req),
    .o_gnt          (gnt),
    .i_req_addr     (req_addr),
    .i_req_en       (req_en),
    .i_req_we       (req_we),
    .i_req_din      (req_din),
    .o_rd_valid     (rd_valid),
    .o_rd_data      (rd_data),
    .o_tw_info_addr (tw_addr),
    .o_tw_info_en   (tw_en),
    .o_tw_info_we   (tw_we),
    .o_tw_info_din  (tw_din),
    .i_tw_info_dout (tw_dout),
    .o_tw_info_clk  (tw_clk)
  );

  always #5 clk = ~clk;

  // Single-port BRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (tw_en) begin
      if (tw_we) mem[tw_addr] <= tw_din;
      else       tw_dout <= mem[tw_addr];
    end
  end

  function automatic logic [W-1:0] word(input int a);
    word = {16'hF00D, 64'h0123_4567_89AB_CDEF, 16'h0, 16'(a * 257)};
  endfunction

  // Invariants: grant one-hot or zero, read strobe one-hot or zero, no enable without a grant.
  always @(negedge clk) begin
    #4;
    if (rstn) begin
      vectors++;
      if (!$onehot0(gnt) || !$onehot0(rd_valid) || (tw_en && gnt == 2'b00)) begin
        miscompares++;
        $display("FAIL invariant: gnt=%b rd_valid=%b en=%b", gnt, rd_valid, tw_en);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  task automatic release_all;
    req = 2'b00; req_en = 2'b00; req_we = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; req = 2'b11; req_en = 2'b11; req_we = 2'b00;
    req_addr = '0; req_din = '0;
    for (int i = 0; i < 16; i++) mem[i] = word(i);
    #3;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    vectors++; if (rd_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rdv: got %b want 00", rd_valid); end
    vectors++; if (tw_en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", tw_en); end
    @(negedge clk); req = 2'b00; req_en = 2'b00;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL idle_gnt: got %b want 00", gnt); end
    vectors++; if (tw_clk !== clk) begin miscompares++; $display("FAIL tw_clk: got %b want %b", tw_clk, clk); end
  endtask

  task automatic test_contention;
    req = 2'b11;
    #1;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL cont_latency: got %b want 00", gnt); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL cont_first[%0d]: got %b want 01", c, gnt); end
    end
    req = 2'b10;
    @(negedge clk);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL cont_drain: got %b want 00", gnt); end
    @(negedge clk);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL cont_idle: got %b want 00", gnt); end
    @(negedge clk);
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL cont_second: got %b want 10", gnt); end
    req = 2'b00;
    repeat (2) @(negedge clk);
    req = 2'b11;
    @(negedge clk);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL cont_rotate: got %b want 01", gnt); end
    release_all();
  endtask

  task automatic test_single_read;
    req = 2'b01;
    @(negedge clk);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b want 01", gnt); end
    for (int a = 1; a <= 3; a++) begin
      req_en[0] = 1'b1; req_addr[0 +: A] = A'(a);
      @(negedge clk);
      vectors++; if (rd_valid !== 2'b01) begin miscompares++; $display("FAIL single_rdv[%0d]: got %b want 01", a, rd_valid); end
      vectors++; if (rd_data !== word(a)) begin miscompares++; $display("FAIL single_data[%0d]: got %h want %h", a, rd_data, word(a)); end
    end
    req_en[0] = 1'b0;
    @(negedge clk);
    vectors++; if (rd_valid !== 2'b00) begin miscompares++; $display("FAIL single_rdv_off: got %b want 00", rd_valid); end
    release_all();
  endtask

  task automatic test_atomic_scan;
    req = 2'b01;
    @(negedge clk);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL scan_gnt: got %b want 01", gnt); end
    req = 2'b11;
    for (int a = 1; a <= 15; a++) begin
      req_en[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: A] = A'(a);
      @(negedge clk);
      vectors++; if (rd_valid !== 2'b01 || rd_data !== word(a) || gnt !== 2'b01) begin
        miscompares++;
        $display("FAIL scan[%0d]: got rdv=%b gnt=%b data=%h want rdv=01 gnt=01 data=%h", a, rd_valid, gnt, rd_data, word(a));
      end
    end
    req_we[0] = 1'b1; req_addr[0 +: A] = 4'd5; req_din[0 +: W] = WR_WORD;
    @(negedge clk);
    vectors++; if (rd_valid !== 2'b00) begin miscompares++; $display("FAIL scan_write_strobe: got %b want 00", rd_valid); end
    req_en[0] = 1'b0; req_we[0] = 1'b0; req = 2'b10;
    @(negedge clk);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL scan_drain: got %b want 00", gnt); end
    @(negedge clk);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL scan_idle: got %b want 00", gnt); end
    @(negedge clk);
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL scan_handover: got %b want 10", gnt); end
    req_en[1] = 1'b1; req_addr[A +: A] = 4'd5;
    @(negedge clk);
    vectors++; if (rd_valid !== 2'b10) begin miscompares++; $display("FAIL scan_rd1_rdv: got %b want 10", rd_valid); end
    vectors++; if (rd_data[15:0] !== 16'h1234 || rd_data !== WR_WORD) begin
      miscompares++; $display("FAIL scan_taskid: got %h want %h", rd_data, WR_WORD);
    end
    req_en[1] = 1'b0;
  endtask

  // Requester 1 still owns the memory when this starts.
  task automatic test_last_read_release;
    req_en[1] = 1'b1; req_addr[A +: A] = 4'd7;
    @(negedge clk);
    req = 2'b00;
    #1;
    vectors++; if (rd_valid !== 2'b10 || rd_data !== word(7)) begin
      miscompares++; $display("FAIL release_rd: got rdv=%b data=%h want rdv=10 data=%h", rd_valid, rd_data, word(7));
    end
    vectors++; if (tw_en !== 1'b0) begin miscompares++; $display("FAIL release_drop_en: got %b want 0", tw_en); end
    @(negedge clk);
    #1;
    vectors++; if (gnt !== 2'b00 || tw_en !== 1'b0 || rd_valid !== 2'b00) begin
      miscompares++; $display("FAIL release_drain: got gnt=%b en=%b rdv=%b want 00/0/00", gnt, tw_en, rd_valid);
    end
    release_all();
  endtask

  task automatic test_non_owner;
    req = 2'b01;
    @(negedge clk);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL nonown_gnt: got %b want 01", gnt); end
    req_addr[0 +: A] = 4'd9; req_en[0] = 1'b0;
    req[1] = 1'b1; req_en[1] = 1'b1; req_we[1] = 1'b1; req_addr[A +: A] = 4'd3; req_din[W +: W] = '1;
    #1;
    vectors++; if (tw_we !== 1'b0 || tw_en !== 1'b0) begin
      miscompares++; $display("FAIL nonown_pins: got we=%b en=%b want 0/0", tw_we, tw_en);
    end
    vectors++; if (tw_addr !== 4'd9) begin miscompares++; $display("FAIL nonown_addr: got %0d want 9", tw_addr); end
    @(negedge clk);
    req[1] = 1'b0; req_en[1] = 1'b0; req_we[1] = 1'b0;
    req_en[0] = 1'b1; req_addr[0 +: A] = 4'd3;
    @(negedge clk);
    vectors++; if (rd_valid !== 2'b01 || rd_data !== word(3)) begin
      miscompares++; $display("FAIL nonown_mem3: got rdv=%b data=%h want rdv=01 data=%h", rd_valid, rd_data, word(3));
    end
    release_all();
  endtask

  task automatic test_async_reset;
    req = 2'b01;
    @(negedge clk);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL areset_gnt: got %b want 01", gnt); end
    req_en[0] = 1'b1; req_addr[0 +: A] = 4'd2;
    @(negedge clk);
    vectors++; if (rd_valid !== 2'b01 || rd_data !== word(2)) begin
      miscompares++; $display("FAIL areset_pre_rd: got rdv=%b data=%h want rdv=01 data=%h", rd_valid, rd_data, word(2));
    end
    #2 rstn = 1'b0;
    #1;
    vectors++; if (gnt !== 2'b00 || tw_en !== 1'b0 || rd_valid !== 2'b00) begin
      miscompares++; $display("FAIL areset_async: got gnt=%b en=%b rdv=%b want 00/0/00", gnt, tw_en, rd_valid);
    end
    req = 2'b00; req_en = 2'b00;
    @(negedge clk); rstn = 1'b1;
    req = 2'b10;
    @(negedge clk);
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL areset_regrant: got %b want 10", gnt); end
    release_all();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_atomic_scan();
    test_last_read_release();
    test_non_owner();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
